// File: rtl/cm_link_pkg.sv
// Shared definitions for the FPGA-to-Xmega CM link transmitter.
//   CM_W            : width of the CM data bus
//   HALF_PERIOD_DEF : default CLK_50 cycles per strobe phase
//   cm_tx_state_t   : transmit FSM states
package cm_link_pkg;

    localparam int CM_W            = 8;
    localparam int HALF_PERIOD_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2
    } cm_tx_state_t;

endpackage

// File: rtl/cm_link_tx_if.sv
// Byte push port between user logic and cm_link_tx.
//   TX_DATA  : byte to send
//   TX_VALID : TX_DATA valid
//   TX_READY : transmitter FIFO can accept a byte
// master = user side, slave = transmitter side.
interface cm_link_tx_if;
    import cm_link_pkg::*;

    logic [CM_W-1:0] TX_DATA;
    logic            TX_VALID;
    logic            TX_READY;

    modport master (output TX_DATA, output TX_VALID, input  TX_READY);
    modport slave  (input  TX_DATA, input  TX_VALID, output TX_READY);
endinterface

// File: rtl/cm_tx_fifo.sv
// Synchronous FIFO holding bytes waiting for the CM link.
//   clk, rst     : clock, synchronous active-high flush
//   push, wdata  : write request (ignored when full)
//   pop          : read request (ignored when empty)
//   rdata        : head entry, combinational
//   full, empty  : occupancy flags from the registered count
//   count        : number of stored entries
module cm_tx_fifo
    import cm_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CM_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/cm_link_tx.sv
// FPGA-to-Xmega byte transmitter for the CM[7:0] + strobe bus.
// Bytes are queued in a FIFO and presented on CM_OUT for HALF_PERIOD
// cycles of setup before STROBE_OUT rises, then held HALF_PERIOD cycles
// while STROBE_OUT is high. The Xmega latches CM on the rising strobe.
//   CLK_50     : system clock
//   RST        : synchronous active-high reset
//   EN         : transmit enable, only gates starting a new byte
//   tx         : valid/ready byte push port (slave side)
//   CM_OUT     : data for the CM pads
//   CM_OE      : pad output enable (1 = FPGA drives)
//   STROBE_OUT : byte strobe
//   BUSY       : FSM active or FIFO non-empty
//   TX_COUNT   : bytes strobed since reset, wrapping
module cm_link_tx
    import cm_link_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int CNT_W       = 16
) (
    input  logic              CLK_50,
    input  logic              RST,
    input  logic              EN,
    cm_link_tx_if.slave       tx,
    output logic [CM_W-1:0]   CM_OUT,
    output logic              CM_OE,
    output logic              STROBE_OUT,
    output logic              BUSY,
    output logic [CNT_W-1:0]  TX_COUNT
);
    localparam int              HW     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HW-1:0]   RELOAD = HW'(HALF_PERIOD - 1);

    cm_tx_state_t          state, state_d;
    logic [HW-1:0]         cnt, cnt_d;
    logic [CM_W-1:0]       cm_out_d;
    logic                  cm_oe_d, strobe_d;
    logic [CNT_W-1:0]      tx_count_d;

    logic                  pop, full, empty;
    logic [CM_W-1:0]       head;
    logic [$clog2(DEPTH):0] fifo_count;

    // Ready comes purely from registered occupancy, so a pop in the same
    // cycle never opens a slot for a push.
    assign tx.TX_READY = !full;
    assign BUSY        = (state != IDLE) || (fifo_count != '0);

    cm_tx_fifo #(.DEPTH(DEPTH), .W(CM_W)) u_fifo (
        .clk   (CLK_50),
        .rst   (RST),
        .push  (tx.TX_VALID && tx.TX_READY),
        .wdata (tx.TX_DATA),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        cm_out_d   = CM_OUT;
        cm_oe_d    = CM_OE;
        strobe_d   = STROBE_OUT;
        tx_count_d = TX_COUNT;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                strobe_d = 1'b0;
                cm_oe_d  = 1'b0;
                if (EN && !empty) begin
                    pop      = 1'b1;
                    cm_out_d = head;
                    cm_oe_d  = 1'b1;
                    cnt_d    = RELOAD;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    strobe_d   = 1'b1;
                    cnt_d      = RELOAD;
                    tx_count_d = TX_COUNT + CNT_W'(1);
                    state_d    = HIGH;
                end else begin
                    cnt_d = cnt - HW'(1);
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    strobe_d = 1'b0;
                    // Chain straight into the next byte so a stream has
                    // a 2*HALF_PERIOD strobe period with no idle gap.
                    if (EN && !empty) begin
                        pop      = 1'b1;
                        cm_out_d = head;
                        cm_oe_d  = 1'b1;
                        cnt_d    = RELOAD;
                        state_d  = SETUP;
                    end else begin
                        cm_oe_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - HW'(1);
                end
            end
            default: begin
                strobe_d = 1'b0;
                cm_oe_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            CM_OUT     <= '0;
            CM_OE      <= 1'b0;
            STROBE_OUT <= 1'b0;
            TX_COUNT   <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            CM_OUT     <= cm_out_d;
            CM_OE      <= cm_oe_d;
            STROBE_OUT <= strobe_d;
            TX_COUNT   <= tx_count_d;
        end
    end
endmodule
